// File: rtl/joystick_multi.sv
// Multi-channel fake analog joystick: digital 4-way switches drive per-frame
// accelerating axis positions with spring-back, read through a 16-bit I/O port.
module joystick_multi #(
  parameter int NCH       = 2,
  parameter int W         = 8,
  parameter int CENTER    = 127,
  parameter int STEP_MAX  = 4,
  parameter int RECENTER  = 1,
  parameter int FRAME_DIV = 1,
  localparam int CW       = (NCH > 2) ? $clog2(NCH) : 1,
  localparam int AW       = 2 + CW
) (
  input  logic           clk6m,
  input  logic           reset_n,
  input  logic           vblank,
  input  logic [NCH-1:0] js_l,
  input  logic [NCH-1:0] js_r,
  input  logic [NCH-1:0] js_u,
  input  logic [NCH-1:0] js_d,
  input  logic [AW-1:0]  a,
  input  logic           wr_n,
  input  logic           rd_n,
  output logic [15:0]    data_out
);

  localparam int SW   = (STEP_MAX > 1) ? $clog2(STEP_MAX + 1) : 1;
  localparam int DW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int MAXV = (1 << W) - 1;

  // dir remembers the last held direction (1 = toward MAXV) for reversal detection
  typedef struct packed {
    logic [W-1:0]  pos;
    logic [SW-1:0] step;
    logic          dir;
  } axis_t;

  axis_t          horiz [NCH];
  axis_t          vert  [NCH];
  logic           hist;
  logic [DW-1:0]  div;
  logic [W-1:0]   out;
  logic [W-1:0]   rd_sel;
  logic           rise;
  logic           tick;
  logic           unused;

  assign unused   = wr_n;
  assign rise     = vblank & ~hist;
  assign tick     = rise && (div == DW'(FRAME_DIV - 1));
  assign data_out = {{(16 - W){1'b0}}, out};

  function automatic axis_t axis_next(input axis_t cur, input logic dec, input logic inc);
    axis_t nx;
    logic  up;
    int    p;
    int    e;
    nx = cur;
    up = ~dec;
    p  = int'(cur.pos);
    if (dec || inc) begin
      e = (cur.dir != up) ? 1 : int'(cur.step);
      if (up) p = (p + e > MAXV) ? MAXV : p + e;
      else    p = (p < e) ? 0 : p - e;
      nx.step = (e >= STEP_MAX) ? SW'(STEP_MAX) : SW'(e + 1);
      nx.dir  = up;
    end else begin
      nx.step = SW'(1);
      if (p > CENTER)      p = (p - CENTER > RECENTER) ? p - RECENTER : CENTER;
      else if (p < CENTER) p = (CENTER - p > RECENTER) ? p + RECENTER : CENTER;
    end
    nx.pos = W'(p);
    return nx;
  endfunction

  always_comb begin
    rd_sel = '0;
    if (int'(a[AW-1:2]) < NCH) begin
      case (a[1:0])
        2'b01:   rd_sel = vert[a[AW-1:2]].pos;
        2'b11:   rd_sel = horiz[a[AW-1:2]].pos;
        default: rd_sel = '0;
      endcase
    end
  end

  always_ff @(posedge clk6m) begin
    // NOTE: hist tracks vblank even in reset, so a vblank already high at release is not a rise.
    hist <= vblank;
    if (!reset_n) begin
      div <= '0;
      out <= '0;
      for (int i = 0; i < NCH; i++) begin
        horiz[i] <= '{pos: W'(CENTER), step: SW'(1), dir: 1'b0};
        vert[i]  <= '{pos: W'(CENTER), step: SW'(1), dir: 1'b0};
      end
    end else begin
      if (rise) div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        for (int i = 0; i < NCH; i++) begin
          horiz[i] <= axis_next(horiz[i], ~js_l[i], ~js_r[i]);
          vert[i]  <= axis_next(vert[i],  ~js_d[i], ~js_u[i]);
        end
      end
      // Frozen during a read strobe so the CPU sees a stable value.
      if (rd_n) out <= rd_sel;
    end
  end

endmodule
